// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns {g,f,e,d,c,b,a}, anode idle value and digit slot indices.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [1:0] SLOT_SCORE_ONES = 2'd0;
  localparam logic [1:0] SLOT_SCORE_TENS = 2'd1;
  localparam logic [1:0] SLOT_TIME_ONES  = 2'd2;
  localparam logic [1:0] SLOT_TIME_TENS  = 2'd3;

  // Registered pin bundle driven onto an/seg/dp.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } pins_t;

  localparam pins_t PINS_IDLE = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

  // Tens digits sit on the odd slots of each pair.
  function automatic logic is_tens_slot(input logic [1:0] slot);
    return (slot == SLOT_SCORE_TENS) || (slot == SLOT_TIME_TENS);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment pattern; codes above 9 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver: score on an[1:0], timer on an[3:2],
// with frame latching, guard time, leading-zero blanking and blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIV       = 100000,
  parameter int GUARD     = 1000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] score_ones,
  input  logic [3:0] score_tens,
  input  logic [3:0] time_ones,
  input  logic [3:0] time_tens,
  input  logic       blank_lz,
  input  logic       blink_en,
  input  logic [3:0] dp_mask,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [BLK_W-1:0] BLK_MAX   = BLK_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_slot;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_phase_on;
  logic [3:0][3:0]  r_shadow;
  pins_t            r_pins;

  logic             w_cnt_wrap;
  logic             w_frame_end;
  logic             w_phase_on;
  logic [3:0]       w_digit;
  logic [6:0]       w_dec_seg;
  logic             w_lz_blank;
  pins_t            w_pins_nxt;

  assign w_cnt_wrap  = (r_cnt == CNT_MAX);
  assign w_frame_end = w_cnt_wrap && (r_slot == SLOT_TIME_TENS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= SLOT_SCORE_ONES;
    end else if (w_cnt_wrap) begin
      r_cnt  <= '0;
      r_slot <= r_slot + 2'd1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Shadow digits only change at the frame boundary so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_frame_end) begin
      r_shadow[SLOT_SCORE_ONES] <= score_ones;
      r_shadow[SLOT_SCORE_TENS] <= score_tens;
      r_shadow[SLOT_TIME_ONES]  <= time_ones;
      r_shadow[SLOT_TIME_TENS]  <= time_tens;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt  <= '0;
      r_phase_on <= 1'b1;
    end else if (!blink_en) begin
      r_blk_cnt  <= '0;
      r_phase_on <= 1'b1;
    end else if (r_blk_cnt == BLK_MAX) begin
      r_blk_cnt  <= '0;
      r_phase_on <= ~r_phase_on;
    end else begin
      r_blk_cnt  <= r_blk_cnt + 1'b1;
    end
  end

  // Dropping blink_en restores the display without waiting for the phase register.
  assign w_phase_on = r_phase_on || !blink_en;

  assign w_digit    = r_shadow[r_slot];
  assign w_lz_blank = blank_lz && is_tens_slot(r_slot) && (w_digit == 4'd0);

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec_seg)
  );

  always_comb begin
    w_pins_nxt = PINS_IDLE;
    if (r_cnt >= CNT_GUARD) begin
      w_pins_nxt.an  = ~(4'b0001 << r_slot);
      w_pins_nxt.seg = w_lz_blank ? SEG_BLANK : w_dec_seg;
      w_pins_nxt.dp  = ~dp_mask[r_slot];
      if (!w_phase_on) begin
        w_pins_nxt.an = AN_OFF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pins <= PINS_IDLE;
    end else begin
      r_pins <= w_pins_nxt;
    end
  end

  assign an  = r_pins.an;
  assign seg = r_pins.seg;
  assign dp  = r_pins.dp;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model pushes
// expected pins every clock, a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int DIV       = 8;
  localparam int GUARD     = 2;
  localparam int BLINK_DIV = 64;
  localparam int FRAME     = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] score_ones = '0;
  logic [3:0] score_tens = '0;
  logic [3:0] time_ones = '0;
  logic [3:0] time_tens = '0;
  logic       blank_lz = 1'b0;
  logic       blink_en = 1'b0;
  logic [3:0] dp_mask = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  // Reference state: cycles since reset, consecutive blink cycles, latched frame.
  int          m_n = 0;
  int          m_k = 0;
  logic [15:0] m_sh = '0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIV       (DIV),
    .GUARD     (GUARD),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score_ones (score_ones),
    .score_tens (score_tens),
    .time_ones  (time_ones),
    .time_tens  (time_tens),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .dp_mask    (dp_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [11:0] model_pins(input int n, input int k, input logic [15:0] sh,
                                             input logic blank, input logic ben,
                                             input logic [3:0] dpm);
    int         cnt;
    int         slot;
    logic       on;
    logic [3:0] d;
    logic [3:0] a;
    logic [6:0] s;
    cnt  = n % DIV;
    slot = (n / DIV) % 4;
    on   = !ben || ((k / BLINK_DIV) % 2 == 0);
    d    = sh[slot*4 +: 4];
    if (cnt < GUARD) return {4'hF, 7'h7F, 1'b1};
    a = 4'hF;
    a[slot] = 1'b0;
    if (!on) a = 4'hF;
    s = (blank && (slot == 1 || slot == 3) && d == 4'd0) ? 7'h7F : seg_of(d);
    return {a, s, !dpm[slot]};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n  <= 0;
      m_k  <= 0;
      m_sh <= '0;
    end else begin
      exp_q.push_back(model_pins(m_n, m_k, m_sh, blank_lz, blink_en, dp_mask));
      if (m_n % FRAME == FRAME - 1)
        m_sh <= {time_tens, time_ones, score_tens, score_ones};
      m_n <= m_n + 1;
      m_k <= blink_en ? m_k + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      n_tests++;
      if ({an, seg, dp} !== mon_exp) begin
        n_fail++;
        $display("FAIL pins t=%0t got an=%b seg=%h dp=%b want an=%b seg=%h dp=%b",
                 $time, an, seg, dp, mon_exp[11:8], mon_exp[7:1], mon_exp[0]);
      end
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic set_digits(input logic [3:0] so, input logic [3:0] st,
                            input logic [3:0] to, input logic [3:0] tt);
    score_ones = so;
    score_tens = st;
    time_ones  = to;
    time_tens  = tt;
  endtask

  // Zeros and valid BCD are favoured so blanking and the decode table both get exercised.
  function automatic logic [3:0] rand_digit();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 4'd0;
    if (r < 8) return 4'($urandom_range(0, 9));
    return 4'($urandom_range(10, 15));
  endfunction

  task automatic rand_inputs();
    set_digits(rand_digit(), rand_digit(), rand_digit(), rand_digit());
    blank_lz = 1'($urandom_range(0, 1));
    dp_mask  = 4'($urandom_range(0, 15));
  endtask

  task automatic check_direct(input string name, input logic [11:0] got, input logic [11:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_frame_pos(input int pos, input string name);
    int guard_cnt;
    guard_cnt = 0;
    while ((m_n % FRAME) != pos && guard_cnt < 2 * FRAME) begin
      tick(1);
      guard_cnt++;
    end
    n_tests++;
    if ((m_n % FRAME) != pos) begin
      n_fail++;
      $display("FAIL %s frame position got=%0d want=%0d", name, m_n % FRAME, pos);
    end
  endtask

  initial begin
    int bound;
    tick(3);
    rst_n = 1'b1;

    set_digits(4'd4, 4'd2, 4'd9, 4'd5);
    tick(FRAME * 3);

    wait_frame_pos(DIV + 3, "slot1_wait");
    score_ones = 4'd7;
    tick(FRAME * 2);

    blank_lz = 1'b1;
    set_digits(4'd3, 4'd0, 4'd6, 4'd0);
    tick(FRAME * 2);
    blank_lz = 1'b0;
    tick(FRAME * 2);

    time_ones = 4'hC;
    dp_mask   = 4'b0100;
    tick(FRAME * 2);

    repeat (60) begin
      rand_inputs();
      tick($urandom_range(1, FRAME * 2));
    end

    blink_en = 1'b1;
    repeat (8) begin
      rand_inputs();
      tick(40);
    end
    bound = 0;
    while (!(((m_k / BLINK_DIV) % 2 == 1) && (m_k % BLINK_DIV == 10)) && bound < 4 * BLINK_DIV) begin
      tick(1);
      bound++;
    end
    n_tests++;
    if (bound >= 4 * BLINK_DIV) begin
      n_fail++;
      $display("FAIL blink_off_wait got=timeout want=off phase");
    end
    blink_en = 1'b0;
    tick(FRAME * 2);

    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    dp_mask = 4'b1111;
    tick(FRAME);
    wait_frame_pos(2 * DIV + 4, "slot2_wait");
    #1 rst_n = 1'b0;
    #1 check_direct("reset_async", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    tick(3);
    check_direct("reset_hold", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
    rst_n = 1'b1;
    tick(FRAME * 2);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=time limit want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
